// File: rtl/jiacheng_pkg.sv
// jiacheng_pkg: shared constants, op encodings and FSM state type for the jiacheng arithmetic unit.
package jiacheng_pkg;
  localparam int W = 6;
  localparam int PW = 2 * W;
  localparam int MUL_STEPS = 6;
  localparam int CW = $clog2(MUL_STEPS);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ABS = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;
  typedef enum logic {IDLE, MUL} state_e;
endpackage

// File: rtl/jiacheng_mul_seq.sv
// jiacheng_mul_seq: LSB-first shift-add multiplier, MUL_STEPS steps; done_o/p_o are valid on the final step edge.
module jiacheng_mul_seq
  import jiacheng_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  output logic          done_o,
  output logic [PW-1:0] p_o
);
  logic [PW-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [W-1:0]  mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          act_q, act_d;
  // p_o is the accumulator after the current step, so the last step's sum is usable on the same edge
  always_comb begin
    p_o      = acc_q + (mplier_q[0] ? mcand_q : '0);
    done_o   = act_q && (cnt_q == CW'(MUL_STEPS - 1));
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    act_d    = act_q;
    if (start_i) begin
      mcand_d  = {{(PW-W){1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
      act_d    = 1'b1;
    end else if (act_q) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = p_o;
      cnt_d    = cnt_q + 1'b1;
      act_d    = !done_o;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      act_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      act_q    <= act_d;
    end
  end
endmodule

// File: rtl/jiacheng.sv
// jiacheng: registered 6-bit add/sub/absdiff/multiply unit with valid/busy handshake.
// JIACHENG_SAT_EN: when defined, multiply overflow saturates c to 127 instead of truncating.
module jiacheng
  import jiacheng_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   sl,
  output logic [W:0]   c,
  output logic         ovf,
  output logic         busy,
  output logic         out_valid
);
  state_e        state_q, state_d;
  logic [W:0]    c_q, c_d, alu, mul_c;
  logic          ovf_q, ovf_d, ov_q, ov_d, mul_ovf, mul_start, mul_done;
  logic [PW-1:0] p;
  assign mul_start = in_valid && (state_q == IDLE) && (sl == OP_MUL);
  jiacheng_mul_seq u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mul_start),
    .a_i     (a),
    .b_i     (b),
    .done_o  (mul_done),
    .p_o     (p)
  );
  always_comb begin
    alu = (sl == OP_ADD) ? {1'b0, a} + {1'b0, b} :
          (sl == OP_SUB) ? {1'b0, a} - {1'b0, b} :
          (a >= b)       ? {1'b0, a - b} : {1'b0, b - a};
    mul_ovf = |p[PW-1:W+1];
`ifdef JIACHENG_SAT_EN
    mul_c = mul_ovf ? '1 : p[W:0];
`else
    mul_c = p[W:0];
`endif
    state_d = state_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    ov_d    = 1'b0;
    if (state_q == IDLE && in_valid) begin
      state_d = (sl == OP_MUL) ? MUL : IDLE;
      c_d     = (sl == OP_MUL) ? c_q : alu;
      ovf_d   = (sl == OP_MUL) ? ovf_q : 1'b0;
      ov_d    = (sl != OP_MUL);
    end else if (state_q == MUL && mul_done) begin
      state_d = IDLE;
      c_d     = mul_c;
      ovf_d   = mul_ovf;
      ov_d    = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      ov_q    <= ov_d;
    end
  end
  assign c         = c_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q == MUL);
  assign out_valid = ov_q;
endmodule

// File: tb/tb_jiacheng.sv
// tb_jiacheng: directed plus randomized checks of jiacheng against a cycle-count reference model.
module tb_jiacheng;
  logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [5:0] a = '0, b = '0;
  logic [1:0] sl = '0;
  logic [6:0] c;
  logic       ovf, busy, out_valid;
  int n_chk = 0, n_fail = 0;
  int exp_c = 0, exp_ovf = 0, exp_ov = 0, left = 0, pend_c = 0, pend_ovf = 0;
  jiacheng dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sl        (sl),
    .c         (c),
    .ovf       (ovf),
    .busy      (busy),
    .out_valid (out_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  task automatic cycle(input bit v, input logic [5:0] aa, input logic [5:0] bb, input logic [1:0] op);
    int p;
    in_valid = v; a = aa; b = bb; sl = op;
    @(posedge clk);
    exp_ov = 0;
    if (!rst_n) begin
      left = 0; exp_c = 0; exp_ovf = 0;
    end else if (left > 0) begin
      left--;
      if (left == 0) begin exp_c = pend_c; exp_ovf = pend_ovf; exp_ov = 1; end
    end else if (v) begin
      if (op == 2'd3) begin
        p = int'(aa) * int'(bb);
        pend_ovf = (p > 127);
`ifdef JIACHENG_SAT_EN
        pend_c = (p > 127) ? 127 : p;
`else
        pend_c = p % 128;
`endif
        left = 6;
      end else begin
        exp_c = (op == 2'd0) ? int'(aa) + int'(bb) :
                (op == 2'd1) ? (int'(aa) - int'(bb)) & 127 :
                (aa >= bb)   ? int'(aa) - int'(bb) : int'(bb) - int'(aa);
        exp_ovf = 0; exp_ov = 1;
      end
    end
    #1;
    chk("c", c, exp_c);
    chk("ovf", ovf, exp_ovf);
    chk("busy", busy, int'(left > 0));
    chk("out_valid", out_valid, exp_ov);
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 6'($urandom), 6'($urandom), 2'($urandom));
  endtask
  initial begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle(1'b1, 6'($urandom), 6'($urandom), 2'($urandom));
    rst_n = 1'b1;
    idle(2);
    cycle(1'b1, 6'd63, 6'd63, 2'd0);
    chk("add126", c, 126);
    idle(1);
    cycle(1'b1, 6'd4, 6'd10, 2'd1);
    chk("sub_neg6", c, 7'h7A);
    cycle(1'b1, 6'd4, 6'd10, 2'd2);
    chk("abs6", c, 6);
    chk("abs_ov", out_valid, 1);
    cycle(1'b1, 6'd4, 6'd10, 2'd3);
    for (int i = 0; i < 6; i++) begin
      if (i == 1) cycle(1'b1, 6'd1, 6'd1, 2'd0);
      else cycle(1'b0, 6'd0, 6'd0, 2'd0);
    end
    chk("mul40", c, 40);
    cycle(1'b1, 6'd63, 6'd63, 2'd3);
    idle(6);
    chk("mul_ovf", ovf, 1);
`ifdef JIACHENG_SAT_EN
    chk("mul_sat", c, 127);
`else
    chk("mul_trunc", c, 1);
`endif
    cycle(1'b1, 6'd0, 6'd45, 2'd3);
    idle(6);
    chk("mul_zero", c, 0);
    cycle(1'b1, 6'd7, 6'd9, 2'd3);
    idle(2);
    rst_n = 1'b0;
    #1;
    chk("rst_c", c, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ov", out_valid, 0);
    exp_c = 0; exp_ovf = 0; left = 0;
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    cycle(1'b1, 6'd7, 6'd9, 2'd3);
    idle(6);
    chk("mul63", c, 63);
    for (int i = 0; i < 400; i++)
      cycle(($urandom % 3) != 0, 6'($urandom), 6'($urandom), 2'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
